// File: rtl/uart_hex_word_assembler_pkg.sv
// ---------------------------------------------------------------------------
// uart_hex_word_assembler_pkg
//   Shared definitions for the UART hex word assembler: ASCII codes used by
//   the character classifier, the assembler FSM state type and a helper that
//   maps a known-hex ASCII code to its nibble value.
//   Optional feature macro (see uart_hex_char_class): UART_HEX_LOWERCASE_EN
// ---------------------------------------------------------------------------
package uart_hex_word_assembler_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_F_UC = 8'h46;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_F_LC = 8'h66;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  // Digits '0'-'9' carry their value in the low nibble; letters 'A'-'F' and
  // 'a'-'f' have low nibble 1..6, so adding 9 yields 0xA..0xF.
  function automatic logic [3:0] ascii_to_nibble(input logic [7:0] ch);
    if (ch <= ASCII_9) return ch[3:0];
    else               return ch[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/uart_hex_word_assembler_if.sv
// ---------------------------------------------------------------------------
// uart_hex_word_assembler_if
//   Bundles the receive-byte strobe, the word valid/ready port and the status
//   pulses of the hex word assembler.
//   master : byte source / word consumer (drives rx_data, rx_valid, word_ready)
//   slave  : the assembler (drives word_out, digit_cnt, word_valid, err_*, busy)
// ---------------------------------------------------------------------------
interface uart_hex_word_assembler_if #(
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DATA_W / 4 + 1);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] word_out;
  logic [CNT_W-1:0]  digit_cnt;
  logic              word_valid;
  logic              word_ready;
  logic              err_char;
  logic              err_ovf;
  logic              err_busy;
  logic              busy;

  modport master (
    output rx_data, rx_valid, word_ready,
    input  word_out, digit_cnt, word_valid, err_char, err_ovf, err_busy, busy
  );

  modport slave (
    input  rx_data, rx_valid, word_ready,
    output word_out, digit_cnt, word_valid, err_char, err_ovf, err_busy, busy
  );
endinterface

// File: rtl/uart_hex_char_class.sv
// ---------------------------------------------------------------------------
// uart_hex_char_class
//   Combinational classifier for one received ASCII byte.
//   ch_i       : received byte
//   is_digit_o : byte is a hex digit ('0'-'9', 'A'-'F', plus 'a'-'f' when
//                UART_HEX_LOWERCASE_EN is defined)
//   is_term_o  : byte is CR or LF
//   nibble_o   : digit value, 0 when not a digit
//   Macro: UART_HEX_LOWERCASE_EN enables lowercase hex letters.
// ---------------------------------------------------------------------------
module uart_hex_char_class
  import uart_hex_word_assembler_pkg::*;
(
  input  logic [7:0] ch_i,
  output logic       is_digit_o,
  output logic       is_term_o,
  output logic [3:0] nibble_o
);

  logic dig_num;
  logic dig_uc;
  logic dig_lc;

  assign dig_num = (ch_i >= ASCII_0)    && (ch_i <= ASCII_9);
  assign dig_uc  = (ch_i >= ASCII_A_UC) && (ch_i <= ASCII_F_UC);
`ifdef UART_HEX_LOWERCASE_EN
  assign dig_lc  = (ch_i >= ASCII_A_LC) && (ch_i <= ASCII_F_LC);
`else
  assign dig_lc  = 1'b0;
`endif

  always_comb begin
    is_digit_o = dig_num || dig_uc || dig_lc;
    is_term_o  = (ch_i == ASCII_CR) || (ch_i == ASCII_LF);
    nibble_o   = is_digit_o ? ascii_to_nibble(ch_i) : 4'h0;
  end

endmodule

// File: rtl/uart_hex_word_assembler.sv
// ---------------------------------------------------------------------------
// uart_hex_word_assembler
//   Accumulates received ASCII hex digits MSB-first into a DATA_W word and
//   offers it on a valid/ready port when CR or LF arrives. Illegal characters
//   and digit overflow raise one-cycle error pulses and the block then drops
//   bytes until the next terminator.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears partial words and all outputs
//   bus   : uart_hex_word_assembler_if.slave (rx byte in, word/status out)
//   Macro: UART_HEX_LOWERCASE_EN (lowercase hex digits, in uart_hex_char_class)
// ---------------------------------------------------------------------------
module uart_hex_word_assembler
  import uart_hex_word_assembler_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_hex_word_assembler_if.slave   bus
);

  localparam int MAX_DIG = DATA_W / 4;
  localparam int CNT_W   = $clog2(MAX_DIG + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_char_q, err_char_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_busy_q, err_busy_d;

  logic              is_digit;
  logic              is_term;
  logic [3:0]        nibble;

  uart_hex_char_class u_class (
    .ch_i       (bus.rx_data),
    .is_digit_o (is_digit),
    .is_term_o  (is_term),
    .nibble_o   (nibble)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_char_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_char_q <= err_char_d;
      err_ovf_q  <= err_ovf_d;
      err_busy_q <= err_busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_char_d = 1'b0;
    err_ovf_d  = 1'b0;
    err_busy_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A stray terminator between words is harmless and ignored.
        if (bus.rx_valid) begin
          if (is_digit) begin
            acc_d   = {{(DATA_W-4){1'b0}}, nibble};
            cnt_d   = CNT_W'(1);
            state_d = ST_COLLECT;
          end else if (!is_term) begin
            err_char_d = 1'b1;
            state_d    = ST_DISCARD;
          end
        end
      end
      ST_COLLECT: begin
        if (bus.rx_valid) begin
          if (is_digit) begin
            if (cnt_q == CNT_W'(MAX_DIG)) begin
              err_ovf_d = 1'b1;
              state_d   = ST_DISCARD;
            end else begin
              acc_d = {acc_q[DATA_W-5:0], nibble};
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_term) begin
            state_d = ST_HOLD;
          end else begin
            err_char_d = 1'b1;
            state_d    = ST_DISCARD;
          end
        end
      end
      ST_HOLD: begin
        // Word stays frozen; any byte arriving now, even on the accept
        // cycle, is lost and reported.
        if (bus.rx_valid) err_busy_d = 1'b1;
        if (bus.word_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (bus.rx_valid && is_term) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.word_out   = acc_q;
  assign bus.digit_cnt  = cnt_q;
  assign bus.word_valid = (state_q == ST_HOLD);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.err_char   = err_char_q;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.err_busy   = err_busy_q;

endmodule

// File: tb/tb_uart_hex_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_hex_word_assembler
//   Self-checking bench: directed scenarios plus randomized byte streams for
//   a 32-bit assembler, and a few directed bytes into an 8-bit instance.
//   The reference model keeps the received digits in a queue and tracks
//   "word pending" / "discarding" flags, predicting per byte the error pulse,
//   the word on offer and the busy flag.
// ---------------------------------------------------------------------------
module tb_uart_hex_word_assembler;

  localparam int MAXD = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_hex_word_assembler_if #(.DATA_W(32)) bus32 ();
  uart_hex_word_assembler_if #(.DATA_W(8))  bus8 ();

  uart_hex_word_assembler #(.DATA_W(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  uart_hex_word_assembler #(.DATA_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int dq[$];
  bit pend = 0;
  bit disc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // -1 illegal, -2 terminator, else digit value
  function automatic int hex_val(input logic [7:0] b);
    string up = "0123456789ABCDEF";
`ifdef UART_HEX_LOWERCASE_EN
    string lo = "0123456789abcdef";
`endif
    if (b == 8'h0D || b == 8'h0A) return -2;
    for (int i = 0; i < 16; i++) begin
      if (b == up[i]) return i;
`ifdef UART_HEX_LOWERCASE_EN
      if (b == lo[i]) return i;
`endif
    end
    return -1;
  endfunction

  function automatic logic [63:0] fold();
    logic [63:0] v = 0;
    foreach (dq[i]) v = (v << 4) | 64'(dq[i]);
    return v;
  endfunction

  task automatic chk_outputs(input bit e_char, input bit e_ovf, input bit e_busy);
    chk("err_char", 64'(bus32.err_char), 64'(e_char));
    chk("err_ovf", 64'(bus32.err_ovf), 64'(e_ovf));
    chk("err_busy", 64'(bus32.err_busy), 64'(e_busy));
    chk("word_valid", 64'(bus32.word_valid), 64'(pend));
    chk("busy", 64'(bus32.busy), 64'(pend || disc || dq.size() > 0));
    if (!disc) begin
      chk("digit_cnt", 64'(bus32.digit_cnt), 64'(dq.size()));
      chk("word_out", 64'(bus32.word_out), fold());
    end
  endtask

  // Called at a negedge; presents one byte for one cycle.
  task automatic send_byte(input logic [7:0] b);
    int v;
    bit ec = 0, eo = 0, eb = 0;
    v = hex_val(b);
    if (pend) eb = 1;
    else if (disc) begin
      if (v == -2) disc = 0;
    end else if (v >= 0) begin
      if (dq.size() == MAXD) begin eo = 1; disc = 1; dq.delete(); end
      else dq.push_back(v);
    end else if (v == -2) begin
      if (dq.size() > 0) pend = 1;
    end else begin
      ec = 1; disc = 1; dq.delete();
    end
    bus32.rx_data  = b;
    bus32.rx_valid = 1'b1;
    @(negedge clk);
    bus32.rx_valid = 1'b0;
    chk_outputs(ec, eo, eb);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_outputs(0, 0, 0);
    end
  endtask

  // Raise ready for one cycle (optionally colliding with a byte).
  task automatic accept(input bit with_byte, input logic [7:0] b);
    bus32.word_ready = 1'b1;
    bus32.rx_data    = b;
    bus32.rx_valid   = with_byte;
    @(negedge clk);
    bus32.rx_valid   = 1'b0;
    bus32.word_ready = 1'b0;
    pend = 0;
    dq.delete();
    chk_outputs(0, 0, with_byte);
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    string hx = "0123456789ABCDEF";
    string lc = "abcdef";
    if (r < 60) return hx[$urandom_range(0, 15)];
    if (r < 75) return ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
    if (r < 82) return lc[$urandom_range(0, 5)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic send8(input logic [7:0] b);
    bus8.rx_data  = b;
    bus8.rx_valid = 1'b1;
    @(negedge clk);
    bus8.rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus32.rx_data = 8'h00; bus32.rx_valid = 1'b0; bus32.word_ready = 1'b0;
    bus8.rx_data  = 8'h00; bus8.rx_valid  = 1'b0; bus8.word_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_word_out", 64'(bus32.word_out), 64'h0);
    chk("rst_valid", 64'(bus32.word_valid), 64'h0);
    chk("rst_busy", 64'(bus32.busy), 64'h0);
    chk("rst_errs", 64'({bus32.err_char, bus32.err_ovf, bus32.err_busy}), 64'h0);
    reset = 1'b0;
    idle(2);

    // 1: basic word with ready already high
    bus32.word_ready = 1'b1;
    send_str("1A3F\r");
    chk("t1_word", 64'(bus32.word_out), 64'h1A3F);
    chk("t1_cnt", 64'(bus32.digit_cnt), 64'd4);
    accept(0, 8'h00);

    // 2: overflow then recovery
    send_str("123456789\n");
    send_str("5\r");
    chk("t2_word", 64'(bus32.word_out), 64'h5);
    accept(0, 8'h00);

    // 3: illegal character then recovery
    send_str("12G4\r");
    send_str("FF\r");
    chk("t3_word", 64'(bus32.word_out), 64'hFF);
    accept(0, 8'h00);

    // 4: consumer stalls, byte collides with pending word
    send_str("7E\n");
    idle(3);
    send_byte("3");
    idle(6);
    chk("t4_word", 64'(bus32.word_out), 64'h7E);
    accept(0, 8'h00);
    idle(1);

    // 5: bare terminators from IDLE
    send_str("\r\n\r");

    // 6: lowercase letters
    send_str("ab\r");
`ifdef UART_HEX_LOWERCASE_EN
    chk("t6_word", 64'(bus32.word_out), 64'hAB);
    accept(0, 8'h00);
`else
    chk("t6_novalid", 64'(bus32.word_valid), 64'h0);
`endif

    // reset mid-word
    send_str("12");
    reset = 1'b1;
    #1;
    chk("mid_rst_word", 64'(bus32.word_out), 64'h0);
    chk("mid_rst_cnt", 64'(bus32.digit_cnt), 64'h0);
    chk("mid_rst_busy", 64'(bus32.busy), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    dq.delete(); pend = 0; disc = 0;
    idle(2);
    send_str("3\r");
    chk("post_rst_word", 64'(bus32.word_out), 64'h3);
    accept(1, "9");

    // 8-bit instance: word and overflow
    bus8.word_ready = 1'b1;
    send8("A"); send8("B"); send8(8'h0D);
    chk("w8_valid", 64'(bus8.word_valid), 64'h1);
    chk("w8_word", 64'(bus8.word_out), 64'hAB);
    chk("w8_cnt", 64'(bus8.digit_cnt), 64'd2);
    @(negedge clk);
    chk("w8_accepted", 64'(bus8.word_valid), 64'h0);
    send8("A"); send8("B"); send8("C");
    chk("w8_ovf", 64'(bus8.err_ovf), 64'h1);
    send8(8'h0A);
    chk("w8_ovf_novalid", 64'(bus8.word_valid), 64'h0);
    chk("w8_ovf_idle", 64'(bus8.busy), 64'h0);

    // randomized streams
    for (int it = 0; it < 1500; it++) begin
      if (pend) begin
        int r = $urandom_range(0, 99);
        if (r < 25)      send_byte(rand_byte());
        else if (r < 45) idle(1);
        else             accept($urandom_range(0, 3) == 0, rand_byte());
      end else if ($urandom_range(0, 9) == 0) begin
        idle(1);
      end else begin
        send_byte(rand_byte());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
